// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with a single outstanding memory request,
// a one-entry response buffer for decode stalls, and the IF/ID register.
// Optional feature: define FETCH_ALIGN_CHECK_EN to add the fetch_misalign
// output, which flags a misaligned PC instead of issuing a memory request.
module if_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        flush,
  output logic        pc_wena,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0040_0000;
  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t          state;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] buf_instr;

  logic misalign_c;
  logic accept_c;
  logic load_mem_c;
  logic load_buf_c;

  // A misaligned PC in REQ is reported instead of being sent to memory
`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign_c = (state == S_REQ) && (pc_in[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  // Request, acceptance and IF/ID write decode
  assign imem_req   = (state == S_REQ) && !misalign_c;
  assign imem_addr  = pc_in;
  assign accept_c   = imem_req && imem_ready;
  assign load_mem_c = (state == S_WAIT) && imem_rvalid && !flush && !stall;
  assign load_buf_c = (state == S_HOLD) && !flush && !stall;
  assign pc_wena    = !rst && (load_mem_c || load_buf_c);

  // Fetch FSM: request address capture and stall buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      buf_instr <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (accept_c) begin
            addr_q <= pc_in;
            state  <= flush ? S_DROP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            state <= imem_rvalid ? S_REQ : S_DROP;
          end else if (imem_rvalid) begin
            if (stall) begin
              buf_instr <= imem_rdata;
              state     <= S_HOLD;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (flush) begin
            buf_instr <= '0;
            state     <= S_REQ;
          end else if (!stall) begin
            state <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // IF/ID register: flush > stall > new instruction > bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= RESET_PC;
      if_id_pc4   <= XLEN'(RESET_PC + INSTR_BYTES);
      if_id_instr <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_misalign <= 1'b0;
`endif
    end else if (flush) begin
      if_id_valid <= 1'b0;
      if_id_instr <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_misalign <= 1'b0;
`endif
    end else if (stall) begin
      if_id_valid <= if_id_valid;
    end else if (load_mem_c) begin
      if_id_valid <= 1'b1;
      if_id_pc    <= addr_q;
      if_id_pc4   <= XLEN'(addr_q + INSTR_BYTES);
      if_id_instr <= imem_rdata;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_misalign <= 1'b0;
`endif
    end else if (load_buf_c) begin
      if_id_valid <= 1'b1;
      if_id_pc    <= addr_q;
      if_id_pc4   <= XLEN'(addr_q + INSTR_BYTES);
      if_id_instr <= buf_instr;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_misalign <= 1'b0;
`endif
    end else if (misalign_c) begin
      if_id_valid <= 1'b1;
      if_id_pc    <= pc_in;
      if_id_pc4   <= XLEN'(pc_in + INSTR_BYTES);
      if_id_instr <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_misalign <= 1'b1;
`endif
    end else begin
      if_id_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_misalign <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch with hand-computed expected values.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        stall;
  logic        flush;
  logic        pc_wena;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int n_checks = 0;
  int n_errors = 0;

  if_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .stall       (stall),
    .flush       (flush),
    .pc_wena     (pc_wena),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; pc_in = 32'h0040_0000;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    cyc(); cyc();

    // Reset state
    check_eq("rst_valid", 32'(if_id_valid), 32'd0);
    check_eq("rst_pc",    if_id_pc,         32'h0040_0000);
    check_eq("rst_pc4",   if_id_pc4,        32'h0040_0004);
    check_eq("rst_instr", if_id_instr,      32'h0);
    check_eq("rst_req",   32'(imem_req),    32'd0);
    check_eq("rst_wena",  32'(pc_wena),     32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif

    // Basic fetch
    rst = 1'b0; #1;
    check_eq("idle_req", 32'(imem_req), 32'd0);
    cyc();
    imem_ready = 1'b1; #1;
    check_eq("req_req",  32'(imem_req), 32'd1);
    check_eq("req_addr", imem_addr,     32'h0040_0000);
    check_eq("req_wena", 32'(pc_wena),  32'd0);
    cyc();
    imem_ready = 1'b0; pc_in = 32'h1234_5678;
    imem_rvalid = 1'b1; imem_rdata = 32'h3C01_0001; #1;
    check_eq("wait_wena", 32'(pc_wena),  32'd1);
    check_eq("wait_req",  32'(imem_req), 32'd0);
    cyc();
    imem_rvalid = 1'b0; #1;
    check_eq("f1_valid", 32'(if_id_valid), 32'd1);
    check_eq("f1_pc",    if_id_pc,         32'h0040_0000);
    check_eq("f1_pc4",   if_id_pc4,        32'h0040_0004);
    check_eq("f1_instr", if_id_instr,      32'h3C01_0001);
    check_eq("f1_wena_off", 32'(pc_wena),  32'd0);

    // Response under stall goes to the buffer
    pc_in = 32'h0040_0004; imem_ready = 1'b1; stall = 1'b1;
    cyc();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h8C22_0008; #1;
    check_eq("stl_wena0", 32'(pc_wena), 32'd0);
    cyc();
    imem_rvalid = 1'b0; #1;
    check_eq("stl_hold_instr", if_id_instr,      32'h3C01_0001);
    check_eq("stl_hold_valid", 32'(if_id_valid), 32'd1);
    cyc();
    cyc();
    check_eq("stl_hold_pc",  if_id_pc,     32'h0040_0000);
    check_eq("stl_wena1",    32'(pc_wena), 32'd0);
    stall = 1'b0; #1;
    check_eq("stl_release_wena", 32'(pc_wena), 32'd1);
    cyc();
    check_eq("stl_new_valid", 32'(if_id_valid), 32'd1);
    check_eq("stl_new_pc",    if_id_pc,         32'h0040_0004);
    check_eq("stl_new_pc4",   if_id_pc4,        32'h0040_0008);
    check_eq("stl_new_instr", if_id_instr,      32'h8C22_0008);

    // Flush in WAIT, late response dropped
    pc_in = 32'h0040_0008; imem_ready = 1'b1;
    cyc();
    check_eq("bubble_valid", 32'(if_id_valid), 32'd0);
    imem_ready = 1'b0; flush = 1'b1; #1;
    check_eq("fl_wena", 32'(pc_wena), 32'd0);
    cyc();
    check_eq("fl_valid", 32'(if_id_valid), 32'd0);
    check_eq("fl_instr", if_id_instr,      32'h0);
    check_eq("drop_req", 32'(imem_req),    32'd0);
    flush = 1'b0; pc_in = 32'h0050_0000;
    cyc();
    check_eq("drop_req2", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    check_eq("drop_wena", 32'(pc_wena), 32'd0);
    cyc();
    imem_rvalid = 1'b0; #1;
    check_eq("drop_valid", 32'(if_id_valid), 32'd0);
    check_eq("drop_instr", if_id_instr,      32'h0);
    check_eq("redir_req",  32'(imem_req),    32'd1);
    check_eq("redir_addr", imem_addr,        32'h0050_0000);
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    cyc();
    imem_rvalid = 1'b0; #1;
    check_eq("redir_pc",    if_id_pc,    32'h0050_0000);
    check_eq("redir_instr", if_id_instr, 32'h0000_0013);

    // Flush and response in the same cycle
    pc_in = 32'h0050_0004; imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0; imem_rvalid = 1'b1; flush = 1'b1; imem_rdata = 32'h1111_1111; #1;
    check_eq("flrv_wena", 32'(pc_wena), 32'd0);
    cyc();
    flush = 1'b0; imem_rvalid = 1'b0; #1;
    check_eq("flrv_valid", 32'(if_id_valid), 32'd0);
    check_eq("flrv_instr", if_id_instr,      32'h0);
    check_eq("flrv_req",   32'(imem_req),    32'd1);
    check_eq("flrv_pc",    if_id_pc,         32'h0050_0000);

    // PC+4 wraps
    pc_in = 32'hFFFF_FFFC; imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    cyc();
    imem_rvalid = 1'b0; #1;
    check_eq("wrap_pc",  if_id_pc,  32'hFFFF_FFFC);
    check_eq("wrap_pc4", if_id_pc4, 32'h0000_0000);

    // Flush in HOLD discards the buffer
    pc_in = 32'h0040_0010; imem_ready = 1'b1; stall = 1'b1;
    cyc();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444;
    cyc();
    imem_rvalid = 1'b0; flush = 1'b1; #1;
    check_eq("hfl_wena", 32'(pc_wena), 32'd0);
    cyc();
    check_eq("hfl_valid", 32'(if_id_valid), 32'd0);
    check_eq("hfl_instr", if_id_instr,      32'h0);
    flush = 1'b0; stall = 1'b0; #1;
    check_eq("hfl_req", 32'(imem_req), 32'd1);
    cyc();
    check_eq("hfl_valid2", 32'(if_id_valid), 32'd0);
    check_eq("hfl_instr2", if_id_instr,      32'h0);

    // Reset mid-request, late response ignored
    pc_in = 32'h0060_0000; imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555; #1;
    check_eq("mrst_wena", 32'(pc_wena),  32'd0);
    check_eq("mrst_req",  32'(imem_req), 32'd0);
    cyc();
    imem_rvalid = 1'b0; #1;
    check_eq("mrst_valid", 32'(if_id_valid), 32'd0);
    check_eq("mrst_pc",    if_id_pc,         32'h0040_0000);
    check_eq("mrst_req2",  32'(imem_req),    32'd1);
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h6666_6666;
    cyc();
    imem_rvalid = 1'b0; #1;
    check_eq("mrst_instr", if_id_instr, 32'h6666_6666);
    check_eq("mrst_pc2",   if_id_pc,    32'h0060_0000);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned PC is flagged instead of fetched
    pc_in = 32'h0040_0002; imem_ready = 1'b1; #1;
    check_eq("mis_req",  32'(imem_req), 32'd0);
    check_eq("mis_wena", 32'(pc_wena),  32'd0);
    cyc();
    check_eq("mis_flag",  32'(fetch_misalign), 32'd1);
    check_eq("mis_valid", 32'(if_id_valid),    32'd1);
    check_eq("mis_instr", if_id_instr,         32'h0);
    check_eq("mis_req2",  32'(imem_req),       32'd0);
    flush = 1'b1; imem_ready = 1'b0;
    cyc();
    flush = 1'b0; #1;
    check_eq("mis_fl_flag",  32'(fetch_misalign), 32'd0);
    check_eq("mis_fl_valid", 32'(if_id_valid),    32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
